// File: rtl/mandelbrot_scheduler.sv
// Slot scheduler for the 3-stage mandelbrot iteration pipeline.
// Recirculates in-flight pixels every lap and retires them on escape or MAX_ITER.
module mandelbrot_scheduler #(
    parameter int LAT      = 3,
    parameter int MAX_ITER = 16,
    parameter int TAG_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_px_valid,
    output logic             o_px_ready,
    input  logic [15:0]      i_px_cx,
    input  logic [15:0]      i_px_cy,
    input  logic [TAG_W-1:0] i_px_tag,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [7:0]       o_res_iter,
    output logic             o_res_escaped,
    output logic [TAG_W-1:0] o_res_tag,
    output logic [15:0]      o_pl_x,
    output logic [15:0]      o_pl_y,
    output logic [15:0]      o_pl_cx,
    output logic [15:0]      o_pl_cy,
    output logic [7:0]       o_pl_cnt,
    input  logic [15:0]      i_pl_x,
    input  logic [15:0]      i_pl_y,
    input  logic [15:0]      i_pl_cx,
    input  logic [15:0]      i_pl_cy,
    input  logic [7:0]       i_pl_cnt,
    output logic             o_busy
);
    localparam int         T     = LAT - 1;
    localparam logic [7:0] MAX_N = 8'(MAX_ITER);

    logic [LAT-1:0]   v_q, v_d;
    logic [LAT-1:0]   dn_q, dn_d;
    logic [LAT-1:0]   es_q, es_d;
    logic [7:0]       it_q [LAT];
    logic [7:0]       it_d [LAT];
    logic [TAG_W-1:0] tg_q [LAT];
    logic [TAG_W-1:0] tg_d [LAT];

    logic             res_v_q, res_v_d;
    logic [7:0]       res_it_q, res_it_d;
    logic             res_es_q, res_es_d;
    logic [TAG_W-1:0] res_tg_q, res_tg_d;

    logic             esc, fin, fin_es, retire, slot_free, accept;
    logic [7:0]       nxt, fin_it;
    logic             in_v, in_dn, in_es;
    logic [7:0]       in_it;
    logic [TAG_W-1:0] in_tg;

    always_comb begin
        esc    = i_pl_cnt != 8'd0;
        nxt    = it_q[T] + 8'd1;
        fin    = v_q[T] & (dn_q[T] | esc | (nxt == MAX_N));
        fin_it = dn_q[T] ? it_q[T] : nxt;
        fin_es = dn_q[T] ? es_q[T] : esc;
        retire = fin & (~res_v_q | i_res_ready);
        slot_free  = ~v_q[T] | retire;
        o_px_ready = slot_free & ~i_rst;
        accept     = o_px_ready & i_px_valid;

        in_v     = 1'b0;
        in_dn    = 1'b0;
        in_es    = 1'b0;
        in_it    = 8'd0;
        in_tg    = '0;
        o_pl_x   = 16'd0;
        o_pl_y   = 16'd0;
        o_pl_cx  = 16'd0;
        o_pl_cy  = 16'd0;
        o_pl_cnt = 8'd0;

        // Occupied slot keeps its lap; a blocked finisher rides along frozen.
        if (!slot_free) begin
            in_v    = 1'b1;
            in_dn   = fin;
            in_es   = fin_es;
            in_it   = fin_it;
            in_tg   = tg_q[T];
            o_pl_x  = i_pl_x;
            o_pl_y  = i_pl_y;
            o_pl_cx = i_pl_cx;
            o_pl_cy = i_pl_cy;
        end else if (accept) begin
            in_v    = 1'b1;
            in_tg   = i_px_tag;
            o_pl_cx = i_px_cx;
            o_pl_cy = i_px_cy;
        end

        v_d  = {v_q[LAT-2:0], in_v};
        dn_d = {dn_q[LAT-2:0], in_dn};
        es_d = {es_q[LAT-2:0], in_es};
        it_d[0] = in_it;
        tg_d[0] = in_tg;
        for (int i = 1; i < LAT; i++) begin
            it_d[i] = it_q[i-1];
            tg_d[i] = tg_q[i-1];
        end

        res_v_d  = res_v_q;
        res_it_d = res_it_q;
        res_es_d = res_es_q;
        res_tg_d = res_tg_q;
        if (retire) begin
            res_v_d  = 1'b1;
            res_it_d = fin_it;
            res_es_d = fin_es;
            res_tg_d = tg_q[T];
        end else if (i_res_ready) begin
            res_v_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v_q      <= '0;
            dn_q     <= '0;
            es_q     <= '0;
            for (int i = 0; i < LAT; i++) begin
                it_q[i] <= 8'd0;
                tg_q[i] <= '0;
            end
            res_v_q  <= 1'b0;
            res_it_q <= 8'd0;
            res_es_q <= 1'b0;
            res_tg_q <= '0;
        end else begin
            v_q      <= v_d;
            dn_q     <= dn_d;
            es_q     <= es_d;
            for (int i = 0; i < LAT; i++) begin
                it_q[i] <= it_d[i];
                tg_q[i] <= tg_d[i];
            end
            res_v_q  <= res_v_d;
            res_it_q <= res_it_d;
            res_es_q <= res_es_d;
            res_tg_q <= res_tg_d;
        end
    end

    assign o_res_valid   = res_v_q;
    assign o_res_iter    = res_it_q;
    assign o_res_escaped = res_es_q;
    assign o_res_tag     = res_tg_q;
    assign o_busy        = (|v_q) | res_v_q;
endmodule

// File: tb/tb_mandelbrot_scheduler.sv
// Directed and random bench for mandelbrot_scheduler with a
// behavioural 3-stage Q4.12 iteration pipeline attached.
module tb_mandelbrot_scheduler;
    localparam int LAT = 3;
    localparam int MAXI = 16;
    localparam int NRND = 200;

    logic        clk = 1'b0;
    logic        i_rst, i_px_valid, o_px_ready;
    logic [15:0] i_px_cx, i_px_cy, i_px_tag;
    logic        o_res_valid, i_res_ready, o_res_escaped;
    logic [7:0]  o_res_iter;
    logic [15:0] o_res_tag;
    logic [15:0] o_pl_x, o_pl_y, o_pl_cx, o_pl_cy;
    logic [7:0]  o_pl_cnt;
    logic [15:0] i_pl_x, i_pl_y, i_pl_cx, i_pl_cy;
    logic [7:0]  i_pl_cnt;
    logic        o_busy;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [15:0] rq_tag [$];
    logic [7:0]  rq_it [$];
    logic        rq_es [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mandelbrot_scheduler #(.LAT(LAT), .MAX_ITER(MAXI), .TAG_W(16)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_px_valid(i_px_valid), .o_px_ready(o_px_ready),
        .i_px_cx(i_px_cx), .i_px_cy(i_px_cy), .i_px_tag(i_px_tag),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
        .o_res_iter(o_res_iter), .o_res_escaped(o_res_escaped),
        .o_res_tag(o_res_tag),
        .o_pl_x(o_pl_x), .o_pl_y(o_pl_y),
        .o_pl_cx(o_pl_cx), .o_pl_cy(o_pl_cy), .o_pl_cnt(o_pl_cnt),
        .i_pl_x(i_pl_x), .i_pl_y(i_pl_y),
        .i_pl_cx(i_pl_cx), .i_pl_cy(i_pl_cy), .i_pl_cnt(i_pl_cnt),
        .o_busy(o_busy)
    );

    // One z <- z^2 + c step; escape flag tests |z|^2 > 4 on the input z.
    function automatic logic [32:0] pstep(input logic [15:0] x, y, cx, cy);
        logic signed [31:0] ax, ay, xx, yy, xy, rx, ry;
        logic signed [33:0] mag;
        ax = 32'($signed(x));
        ay = 32'($signed(y));
        xx = ax * ax;
        yy = ay * ay;
        xy = ax * ay;
        mag = 34'(xx) + 34'(yy);
        rx = ((xx - yy) >>> 12) + 32'($signed(cx));
        ry = (xy >>> 11) + 32'($signed(cy));
        return {rx[15:0], ry[15:0], mag > 34'sd67108864};
    endfunction

    task automatic ref_model(input logic [15:0] cx, cy,
                             output logic [7:0] it, output logic e);
        logic [15:0] x, y;
        logic [32:0] r;
        x = 16'd0;
        y = 16'd0;
        it = 8'd0;
        e = 1'b0;
        for (int n = 1; n <= MAXI; n++) begin
            r = pstep(x, y, cx, cy);
            if (r[0] || n == MAXI) begin
                it = 8'(n);
                e = r[0];
                return;
            end
            x = r[32:17];
            y = r[16:1];
        end
    endtask

    logic [32:0] pv;
    logic [15:0] px [3] = '{16'd0, 16'd0, 16'd0};
    logic [15:0] py [3] = '{16'd0, 16'd0, 16'd0};
    logic [15:0] pcx [3] = '{16'd0, 16'd0, 16'd0};
    logic [15:0] pcy [3] = '{16'd0, 16'd0, 16'd0};
    logic [7:0]  pc [3] = '{8'd0, 8'd0, 8'd0};

    assign pv = pstep(o_pl_x, o_pl_y, o_pl_cx, o_pl_cy);
    always @(posedge clk) begin
        px[0]  <= pv[32:17];
        py[0]  <= pv[16:1];
        pcx[0] <= o_pl_cx;
        pcy[0] <= o_pl_cy;
        pc[0]  <= o_pl_cnt | {7'd0, pv[0]};
        for (int i = 1; i < 3; i++) begin
            px[i]  <= px[i-1];
            py[i]  <= py[i-1];
            pcx[i] <= pcx[i-1];
            pcy[i] <= pcy[i-1];
            pc[i]  <= pc[i-1];
        end
    end
    assign i_pl_x = px[2];
    assign i_pl_y = py[2];
    assign i_pl_cx = pcx[2];
    assign i_pl_cy = pcy[2];
    assign i_pl_cnt = pc[2];

    always begin
        @(negedge clk);
        #2;
        if (o_res_valid && i_res_ready) begin
            rq_tag.push_back(o_res_tag);
            rq_it.push_back(o_res_iter);
            rq_es.push_back(o_res_escaped);
        end
    end

    task automatic clear_q();
        rq_tag.delete();
        rq_it.delete();
        rq_es.delete();
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_px_valid = 1'b0;
        i_px_cx = 16'd0;
        i_px_cy = 16'd0;
        i_px_tag = 16'd0;
        i_res_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_chk++;
        if ({o_res_valid, o_res_escaped, o_busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 000",
                     {o_res_valid, o_res_escaped, o_busy});
        end
        n_chk++;
        if ({o_res_iter, o_res_tag} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_res got %h want 0", {o_res_iter, o_res_tag});
        end
        n_chk++;
        if ({o_pl_x, o_pl_y, o_pl_cx, o_pl_cy, o_pl_cnt} !== 72'd0) begin
            n_fail++;
            $display("FAIL reset_pl got %h want 0",
                     {o_pl_x, o_pl_y, o_pl_cx, o_pl_cy, o_pl_cnt});
        end
        @(negedge clk);
        i_rst = 1'b0;
    endtask

    task automatic test_single_pixel(input logic [15:0] cx, cy, tag,
                                     input int e_n, e_low,
                                     input logic [7:0] e_it,
                                     input logic e_es);
        int n;
        int low;
        bit got;
        clear_q();
        @(negedge clk);
        i_px_valid = 1'b1;
        i_px_cx = cx;
        i_px_cy = cy;
        i_px_tag = tag;
        i_res_ready = 1'b1;
        #1;
        n_chk++;
        if (o_px_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready tag %0d got %b want 1", tag, o_px_ready);
        end
        @(posedge clk);
        n = 1;
        low = 0;
        got = 0;
        while (!got && n < 150) begin
            @(negedge clk);
            i_px_valid = 1'b0;
            #1;
            if (o_res_valid) got = 1;
            else begin
                if (!o_px_ready) low++;
                @(posedge clk);
                n++;
            end
        end
        n_chk++;
        if (n !== e_n) begin
            n_fail++;
            $display("FAIL single_latency tag %0d got %0d want %0d", tag, n, e_n);
        end
        n_chk++;
        if (low !== e_low) begin
            n_fail++;
            $display("FAIL single_ready_low tag %0d got %0d want %0d",
                     tag, low, e_low);
        end
        n_chk++;
        if ({o_res_iter, o_res_escaped, o_res_tag} !== {e_it, e_es, tag}) begin
            n_fail++;
            $display("FAIL single_result got it=%0d e=%b t=%0d want %0d %b %0d",
                     o_res_iter, o_res_escaped, o_res_tag, e_it, e_es, tag);
        end
        @(negedge clk);
        #1;
        n_chk++;
        if ({o_res_valid, o_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_idle got %b want 00", {o_res_valid, o_busy});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] cys [3];
        logic [15:0] et [4];
        logic [7:0]  ei [4];
        logic        ee [4];
        int c1, c4, w;
        cys = '{16'h0000, 16'h1800, 16'h0000};
        et = '{16'd2, 16'd4, 16'd1, 16'd3};
        ei = '{8'd3, 8'd3, 8'd16, 8'd16};
        ee = '{1'b1, 1'b1, 1'b0, 1'b0};
        c1 = 0;
        clear_q();
        i_res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            i_px_valid = 1'b1;
            i_px_cx = 16'd0;
            i_px_cy = cys[i];
            i_px_tag = 16'(i + 1);
            #1;
            if (i == 0) c1 = cyc;
            n_chk++;
            if (o_px_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready tag %0d got %b want 1", i + 1, o_px_ready);
            end
        end
        @(negedge clk);
        i_px_tag = 16'd4;
        i_px_cy = 16'h1800;
        w = 0;
        #1;
        while (!o_px_ready && w < 100) begin
            @(negedge clk);
            #1;
            w++;
        end
        c4 = cyc;
        n_chk++;
        if (c4 - c1 !== 10) begin
            n_fail++;
            $display("FAIL b2b_refuse got %0d want 10", c4 - c1);
        end
        n_chk++;
        if (rq_tag.size() !== 0) begin
            n_fail++;
            $display("FAIL b2b_early got %0d want 0", rq_tag.size());
        end
        @(negedge clk);
        i_px_valid = 1'b0;
        #1;
        n_chk++;
        if ({o_res_valid, o_res_tag} !== {1'b1, 16'd2}) begin
            n_fail++;
            $display("FAIL b2b_first got v=%b t=%0d want 1 2", o_res_valid, o_res_tag);
        end
        w = 0;
        while (rq_tag.size() < 4 && w < 200) begin
            @(negedge clk);
            #3;
            w++;
        end
        n_chk++;
        if (rq_tag.size() !== 4) begin
            n_fail++;
            $display("FAIL b2b_count got %0d want 4", rq_tag.size());
        end
        for (int i = 0; i < 4 && i < rq_tag.size(); i++) begin
            n_chk++;
            if ({rq_tag[i], rq_it[i], rq_es[i]} !== {et[i], ei[i], ee[i]}) begin
                n_fail++;
                $display("FAIL b2b_order %0d got t=%0d it=%0d e=%b want %0d %0d %b",
                         i, rq_tag[i], rq_it[i], rq_es[i], et[i], ei[i], ee[i]);
            end
        end
        w = 0;
        while (o_busy && w < 100) begin
            @(negedge clk);
            w++;
        end
    endtask

    task automatic test_backpressure();
        int w;
        int bad;
        clear_q();
        i_res_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            i_px_valid = 1'b1;
            i_px_cx = 16'd0;
            i_px_cy = 16'd0;
            i_px_tag = 16'(7 + i);
            #1;
            n_chk++;
            if (o_px_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_ready tag %0d got %b want 1", 7 + i, o_px_ready);
            end
        end
        @(negedge clk);
        i_px_valid = 1'b0;
        w = 0;
        while (!o_res_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if ({o_res_valid, o_res_tag, o_res_iter, o_res_escaped}
                !== {1'b1, 16'd7, 8'd16, 1'b0}) bad++;
        end
        n_chk++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL bp_hold got %0d unstable cycles want 0", bad);
        end
        n_chk++;
        if ({o_busy, 8'(rq_tag.size())} !== {1'b1, 8'd0}) begin
            n_fail++;
            $display("FAIL bp_busy got busy=%b n=%0d want 1 0", o_busy, rq_tag.size());
        end
        @(negedge clk);
        i_res_ready = 1'b1;
        repeat (LAT + 1) @(negedge clk);
        #3;
        n_chk++;
        if (rq_tag.size() !== 2) begin
            n_fail++;
            $display("FAIL bp_release got %0d results want 2", rq_tag.size());
        end
        for (int i = 0; i < 2 && i < rq_tag.size(); i++) begin
            n_chk++;
            if ({rq_tag[i], rq_it[i], rq_es[i]} !== {16'(7 + i), 8'd16, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_data %0d got t=%0d it=%0d e=%b want %0d 16 0",
                         i, rq_tag[i], rq_it[i], rq_es[i], 7 + i);
            end
        end
        repeat (60) @(negedge clk);
        n_chk++;
        if ({o_busy, 8'(rq_tag.size())} !== {1'b0, 8'd2}) begin
            n_fail++;
            $display("FAIL bp_after got busy=%b n=%0d want 0 2", o_busy, rq_tag.size());
        end
    endtask

    task automatic test_mid_reset();
        clear_q();
        i_res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            i_px_valid = 1'b1;
            i_px_cx = 16'd0;
            i_px_cy = 16'd0;
            i_px_tag = 16'(11 + i);
        end
        @(negedge clk);
        i_px_valid = 1'b0;
        repeat (10) @(negedge clk);
        n_chk++;
        if (o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_busy got %b want 1", o_busy);
        end
        @(negedge clk);
        i_rst = 1'b1;
        #1;
        n_chk++;
        if ({o_res_valid, o_busy, o_res_escaped, o_res_iter, o_res_tag} !== 27'd0) begin
            n_fail++;
            $display("FAIL rst_mid_res got %h want 0",
                     {o_res_valid, o_busy, o_res_escaped, o_res_iter, o_res_tag});
        end
        n_chk++;
        if ({o_pl_x, o_pl_y, o_pl_cx, o_pl_cy, o_pl_cnt} !== 72'd0) begin
            n_fail++;
            $display("FAIL rst_mid_pl got %h want 0",
                     {o_pl_x, o_pl_y, o_pl_cx, o_pl_cy, o_pl_cnt});
        end
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        repeat (60) @(negedge clk);
        n_chk++;
        if ({o_busy, 8'(rq_tag.size())} !== {1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL rst_ghost got busy=%b n=%0d want 0 0", o_busy, rq_tag.size());
        end
        test_single_pixel(16'h0000, 16'h1800, 16'd14, 10, 2, 8'd3, 1'b1);
    endtask

    task automatic test_random_stream();
        logic [15:0] rcx [NRND];
        logic [15:0] rcy [NRND];
        logic [7:0]  eit [NRND];
        logic        ees [NRND];
        int seen [NRND];
        int idx, guard, k, bad;
        clear_q();
        for (int i = 0; i < NRND; i++) begin
            rcx[i] = 16'(int'($urandom_range(0, 16384)) - 8192);
            rcy[i] = 16'(int'($urandom_range(0, 16384)) - 8192);
            ref_model(rcx[i], rcy[i], eit[i], ees[i]);
            seen[i] = 0;
        end
        idx = 0;
        guard = 0;
        while ((idx < NRND || rq_tag.size() < NRND) && guard < 20000) begin
            @(negedge clk);
            i_res_ready = $urandom_range(0, 3) != 0;
            i_px_valid = (idx < NRND) && ($urandom_range(0, 3) != 0);
            if (idx < NRND) begin
                i_px_cx = rcx[idx];
                i_px_cy = rcy[idx];
                i_px_tag = 16'(100 + idx);
            end
            #1;
            if (i_px_valid && o_px_ready) idx++;
            guard++;
        end
        @(negedge clk);
        i_px_valid = 1'b0;
        i_res_ready = 1'b1;
        #3;
        n_chk++;
        if (guard >= 20000) begin
            n_fail++;
            $display("FAIL rnd_timeout got %0d results want %0d", rq_tag.size(), NRND);
        end
        n_chk++;
        if (rq_tag.size() !== NRND) begin
            n_fail++;
            $display("FAIL rnd_count got %0d want %0d", rq_tag.size(), NRND);
        end
        bad = 0;
        for (int i = 0; i < rq_tag.size(); i++) begin
            k = int'(rq_tag[i]) - 100;
            n_chk++;
            if (k < 0 || k >= NRND) begin
                n_fail++;
                $display("FAIL rnd_tag got %0d want 100..%0d", rq_tag[i], 99 + NRND);
            end else begin
                seen[k]++;
                if ({rq_it[i], rq_es[i]} !== {eit[k], ees[k]}) begin
                    n_fail++;
                    $display("FAIL rnd_result tag %0d got it=%0d e=%b want %0d %b",
                             rq_tag[i], rq_it[i], rq_es[i], eit[k], ees[k]);
                end
            end
        end
        for (int i = 0; i < NRND; i++) if (seen[i] != 1) bad++;
        n_chk++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL rnd_unique got %0d tags not seen once want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_single_pixel(16'h0000, 16'h0000, 16'd5, 49, 15, 8'd16, 1'b0);
        test_single_pixel(16'h0000, 16'h1800, 16'd9, 10, 2, 8'd3, 1'b1);
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        test_random_stream();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mandelbrot_scheduler.md
Name: mandelbrot_scheduler

Overview:
- Sequences pixels through the 3-stage mandelbrot iteration pipeline.
- Keeps LAT pixels in flight, recirculates each pixel's z every lap, and retires a pixel on escape or at MAX_ITER.
- New pixels take slots that have been freed.
- Sits between the pixel-coordinate generator (upstream) and the colour-mapping/framebuffer writer (downstream).

Parameters:
- LAT, 3, pipeline latency in cycles (= number of in-flight slots)
- MAX_ITER, 16, maximum passes per pixel (1..255)
- TAG_W, 16, width of the pixel tag carried with each pixel

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_px_valid  in  1  new pixel offered
- o_px_ready  out  1  new pixel accepted this cycle when high together with i_px_valid
- i_px_cx, i_px_cy  in  16  signed Q4.12 c
- i_px_tag  in  TAG_W  pixel id
- o_res_valid  out  1  result held
- i_res_ready  in  1  downstream accepts result
- o_res_iter  out  8  passes completed
- o_res_escaped  out  1  1 = escaped, 0 = hit MAX_ITER
- o_res_tag  out  TAG_W  pixel id of result
- o_pl_x, o_pl_y, o_pl_cx, o_pl_cy  out  16  pipeline inputs
- o_pl_cnt  out  8  pipeline count input
- i_pl_x, i_pl_y, i_pl_cx, i_pl_cy  in  16  pipeline outputs
- i_pl_cnt  in  8  pipeline count output
- o_busy  out  1  any slot valid or result held

Behaviour:
Reset:
- i_rst asynchronous, active-high.
- Clears all shadow state and the result register.
- o_res_valid=0, o_res_iter=0, o_res_escaped=0, o_res_tag=0, o_busy=0.
- o_pl_*=0.
- Reset mid-operation drops all in-flight pixels. Pipeline garbage returning afterwards is ignored because its shadow valid=0.

Shadow shift register (depth LAT, advances every cycle, no stall):
- Per entry: valid, done, escaped, iter[7:0], tag.
- Entry at tail aligns with the i_pl_* values returning this cycle.

Returning-slot evaluation (combinational, per cycle):
- esc = (i_pl_cnt != 0); n = iter+1.
- Valid, not done: finished = esc or n == MAX_ITER. Result iter = n, escaped = esc.
- Valid, done: already finished; retains its frozen iter/escaped.
- Retire allowed when the result register is empty or i_res_ready=1.
- Finished slot with retire allowed: loads the result register; the slot becomes free.
- Finished slot blocked by a full output: re-injected with done=1 and frozen iter/escaped/tag. Retirement is retried every lap; pipeline data for done slots is don't-care.
- Valid slot, not finished: re-injected with o_pl_x/y = i_pl_x/y, o_pl_cx/cy = i_pl_cx/cy, o_pl_cnt = 0, iter = n.
- o_pl_* are driven combinationally from i_pl_*/i_px_*; the pipeline registers them.

Slot allocation and injection:
- Slot free = returning entry invalid, or retiring this cycle.
- o_px_ready = slot free.
- Accept: inject x=0, y=0, cx, cy, cnt=0; shadow valid=1, done=0, iter=0, tag.
- Free slot and no pixel: inject zeros with valid=0.
- Continuing slots always have priority over new pixels; there is no starvation because every pixel finishes within MAX_ITER laps.

Result register:
- o_res_valid is held until i_res_ready.
- Load and drain in the same cycle is allowed: new data replaces old.
- Results may leave in a different order from entry; the tag identifies the pixel.

Throughput and latency:
- Max one pixel accepted per cycle.
- Pixel latency = passes*LAT + 1 cycles to o_res_valid, absent backpressure.

Other:
- o_busy = OR of shadow valids, or o_res_valid.
- Arithmetic: iter is 8-bit; MAX_ITER ≤ 255 means n never wraps.

Test Plan:
1. Single pixel c=(0,0), MAX_ITER=16, tag=5, i_res_ready=1 → o_res_valid after 49 cycles; iter=16, escaped=0, tag=5; o_px_ready=0 only on that slot's injection cycles.
2. Single pixel c=(0x0000, 0x1800) (0+1.5i) → escapes on pass 3: iter=3, escaped=1, result 10 cycles after accept.
3. Three pixels back-to-back (tags 1,2,3), c = (0,0), (0,1.5i), (0,0) → all accepted in 3 consecutive cycles; a 4th pixel is refused until tag 2 retires; tag 2 returns first; then tags 1, 3 with iter=16.
4. Hold i_res_ready=0 with 2 pixels finishing → first result held stable; second slot recirculates done=1 with unchanged iter; releasing ready delivers it within LAT cycles; no pixel lost or duplicated.
5. Assert i_rst mid-flight with 3 pixels active → all outputs 0 and o_busy=0 immediately; after release, no results emerge from old pixels; a new pixel completes normally.
6. Random stream of 200 pixels with random i_res_ready → every tag appears exactly once; iter/escaped match the reference model of the Q4.12 pipeline.
